// File: rtl/regfile_scoreboard_if.sv
// regfile_scoreboard_if: writeback, reserve, flush and read-port bundle for the register file scoreboard
interface regfile_scoreboard_if #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 5
);
    logic              we;
    logic [ADDR_W-1:0] waddr;
    logic [DATA_W-1:0] wdata;
    logic              rsv_valid;
    logic [ADDR_W-1:0] rsv_addr;
    logic              flush;
    logic              rs1_re;
    logic              rs2_re;
    logic [ADDR_W-1:0] rs1_addr;
    logic [ADDR_W-1:0] rs2_addr;
    logic [DATA_W-1:0] rs1_data;
    logic [DATA_W-1:0] rs2_data;
    logic              rs1_busy;
    logic              rs2_busy;
    logic              stall_o;
    logic [ADDR_W:0]   busy_cnt;

    modport master (
        output we, waddr, wdata, rsv_valid, rsv_addr, flush,
        output rs1_re, rs2_re, rs1_addr, rs2_addr,
        input  rs1_data, rs2_data, rs1_busy, rs2_busy, stall_o, busy_cnt
    );

    modport slave (
        input  we, waddr, wdata, rsv_valid, rsv_addr, flush,
        input  rs1_re, rs2_re, rs1_addr, rs2_addr,
        output rs1_data, rs2_data, rs1_busy, rs2_busy, stall_o, busy_cnt
    );
endinterface

// File: rtl/regfile_scoreboard.sv
// regfile_scoreboard: register file with per-register busy scoreboard; define REGFILE_BYPASS_EN to forward same-cycle writeback to the read ports
module regfile_scoreboard #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 5
) (
    input logic                clk,
    input logic                rst,
    regfile_scoreboard_if.slave bus
);
    localparam int NUM_REGS = 2 ** ADDR_W;
`ifdef REGFILE_BYPASS_EN
    localparam bit BYPASS = 1'b1;
`else
    localparam bit BYPASS = 1'b0;
`endif

    logic [DATA_W-1:0]   regs [NUM_REGS];
    logic [NUM_REGS-1:0] busy;
    logic [NUM_REGS-1:0] busy_nxt;
    logic                wr_en;
    logic                rsv_en;
    logic                cnt_inc;
    logic                cnt_dec;
    logic                hit1;
    logic                hit2;
    logic                byp1;
    logic                byp2;

    // next busy vector and counter deltas; a same-address reserve overrides the writeback clear
    always_comb begin
        wr_en    = bus.we && bus.waddr != '0;
        rsv_en   = bus.rsv_valid && bus.rsv_addr != '0 && !bus.flush;
        cnt_dec  = wr_en && busy[bus.waddr] && !(rsv_en && bus.rsv_addr == bus.waddr);
        cnt_inc  = rsv_en && !busy[bus.rsv_addr];
        busy_nxt = busy;
        if (wr_en)
            busy_nxt[bus.waddr] = 1'b0;
        if (rsv_en)
            busy_nxt[bus.rsv_addr] = 1'b1;
        if (bus.flush)
            busy_nxt = '0;
    end

    // register storage; x0 is never written so it stays zero
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < NUM_REGS; i++)
                regs[i] <= '0;
        end else if (wr_en) begin
            regs[bus.waddr] <= bus.wdata;
        end
    end

    // busy bits and their running population count
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            busy         <= '0;
            bus.busy_cnt <= '0;
        end else begin
            busy         <= busy_nxt;
            bus.busy_cnt <= bus.flush ? '0 : bus.busy_cnt + (ADDR_W + 1)'(cnt_inc) - (ADDR_W + 1)'(cnt_dec);
        end
    end

    // zero-latency read ports with optional writeback forwarding
    always_comb begin
        hit1         = bus.rs1_re && bus.rs1_addr != '0;
        hit2         = bus.rs2_re && bus.rs2_addr != '0;
        byp1         = BYPASS && hit1 && wr_en && bus.waddr == bus.rs1_addr;
        byp2         = BYPASS && hit2 && wr_en && bus.waddr == bus.rs2_addr;
        bus.rs1_data = !hit1 ? '0 : byp1 ? bus.wdata : regs[bus.rs1_addr];
        bus.rs2_data = !hit2 ? '0 : byp2 ? bus.wdata : regs[bus.rs2_addr];
        bus.rs1_busy = hit1 && !byp1 && busy[bus.rs1_addr];
        bus.rs2_busy = hit2 && !byp2 && busy[bus.rs2_addr];
        bus.stall_o  = bus.rs1_busy | bus.rs2_busy;
    end
endmodule

// File: tb/tb_regfile_scoreboard.sv
// tb_regfile_scoreboard: directed and randomized checks of regfile_scoreboard against an array-based reference model
module tb_regfile_scoreboard;
    localparam int DW = 32;
    localparam int AW = 5;
    localparam int NR = 32;

    logic clk = 1'b0;
    logic rst = 1'b0;
    int   checks = 0;
    int   failures = 0;

    logic [DW-1:0] m_regs [NR];
    bit            m_busy [NR];

    regfile_scoreboard_if #(.DATA_W(DW), .ADDR_W(AW)) bus ();

    regfile_scoreboard #(.DATA_W(DW), .ADDR_W(AW)) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    always #5 clk = ~clk;

    // reference model: number of busy registers
    function automatic int pop();
        int n = 0;
        for (int i = 0; i < NR; i++)
            n += int'(m_busy[i]);
        return n;
    endfunction

    // reference model: expected {data, busy} seen on a read port
    function automatic logic [DW:0] exp_rd(logic re, logic [AW-1:0] a);
        if (!re || a == 0)
            return '0;
`ifdef REGFILE_BYPASS_EN
        if (bus.we && bus.waddr == a)
            return {bus.wdata, 1'b0};
`endif
        return {m_regs[a], m_busy[a]};
    endfunction

    // reference model: expected packed output vector
    function automatic logic [72:0] exp_vec();
        logic [DW:0] r1;
        logic [DW:0] r2;
        r1 = exp_rd(bus.rs1_re, bus.rs1_addr);
        r2 = exp_rd(bus.rs2_re, bus.rs2_addr);
        return {r1, r2, r1[0] | r2[0], 6'(pop())};
    endfunction

    function automatic logic [72:0] dut_vec();
        return {bus.rs1_data, bus.rs1_busy, bus.rs2_data, bus.rs2_busy, bus.stall_o, bus.busy_cnt};
    endfunction

    task automatic model_reset();
        for (int i = 0; i < NR; i++) begin
            m_regs[i] = '0;
            m_busy[i] = 1'b0;
        end
    endtask

    task automatic idle();
        bus.we = 0; bus.waddr = 0; bus.wdata = 0;
        bus.rsv_valid = 0; bus.rsv_addr = 0; bus.flush = 0;
        bus.rs1_re = 0; bus.rs2_re = 0; bus.rs1_addr = 0; bus.rs2_addr = 0;
    endtask

    // advance one clock: apply the model at the edge, return at the following negedge
    task automatic tick();
        @(posedge clk);
        if (rst) begin
            if (bus.we && bus.waddr != 0) begin
                m_regs[bus.waddr] = bus.wdata;
                m_busy[bus.waddr] = 1'b0;
            end
            if (bus.flush) begin
                for (int i = 0; i < NR; i++)
                    m_busy[i] = 1'b0;
            end else if (bus.rsv_valid && bus.rsv_addr != 0) begin
                m_busy[bus.rsv_addr] = 1'b1;
            end
        end
        @(negedge clk);
    endtask

    task automatic test_reset();
        idle();
        model_reset();
        rst = 1'b0;
        bus.we = 1; bus.waddr = 3; bus.wdata = 32'hA5A5_A5A5; bus.rsv_valid = 1; bus.rsv_addr = 4;
        tick();
        tick();
        idle();
        rst = 1'b1;
        @(negedge clk);
        for (int a = 0; a < NR; a++) begin
            bus.rs1_re = 1; bus.rs2_re = 1; bus.rs1_addr = AW'(a); bus.rs2_addr = AW'(NR - 1 - a);
            #1;
            checks++;
            if (dut_vec() !== 73'd0) begin
                failures++;
                $display("FAIL reset_read addr=%0d got=%h exp=0", a, dut_vec());
            end
        end
        idle();
    endtask

    task automatic test_reserve_write();
        bus.rsv_valid = 1; bus.rsv_addr = 5;
        tick();
        idle();
        bus.rs1_re = 1; bus.rs1_addr = 5;
        #1;
        checks++;
        if ({bus.rs1_busy, bus.stall_o, bus.busy_cnt} !== {1'b1, 1'b1, 6'd1}) begin
            failures++;
            $display("FAIL reserve_x5 got busy=%b stall=%b cnt=%0d exp 1 1 1", bus.rs1_busy, bus.stall_o, bus.busy_cnt);
        end
        bus.we = 1; bus.waddr = 5; bus.wdata = 32'hDEAD_BEEF;
        tick();
        bus.we = 0;
        #1;
        checks++;
        if ({bus.rs1_data, bus.rs1_busy, bus.stall_o, bus.busy_cnt} !== {32'hDEAD_BEEF, 1'b0, 1'b0, 6'd0}) begin
            failures++;
            $display("FAIL write_x5 got data=%h busy=%b cnt=%0d exp deadbeef 0 0", bus.rs1_data, bus.rs1_busy, bus.busy_cnt);
        end
        idle();
    endtask

    task automatic test_same_cycle();
        logic [DW-1:0] d;
        d = $urandom;
        bus.we = 1; bus.waddr = 7; bus.wdata = d; bus.rsv_valid = 1; bus.rsv_addr = 7;
        tick();
        idle();
        bus.rs1_re = 1; bus.rs1_addr = 7;
        #1;
        checks++;
        if ({bus.rs1_data, bus.rs1_busy, bus.busy_cnt} !== {d, 1'b1, 6'd1}) begin
            failures++;
            $display("FAIL wr_rsv_x7 got data=%h busy=%b cnt=%0d exp %h 1 1", bus.rs1_data, bus.rs1_busy, bus.busy_cnt, d);
        end
        idle();
    endtask

    task automatic test_flush();
        for (int r = 1; r <= 3; r++) begin
            bus.rsv_valid = 1; bus.rsv_addr = AW'(r);
            tick();
        end
        idle();
        #1;
        checks++;
        if (bus.busy_cnt !== 6'd4) begin
            failures++;
            $display("FAIL pre_flush_cnt got=%0d exp=4", bus.busy_cnt);
        end
        bus.flush = 1; bus.rsv_valid = 1; bus.rsv_addr = 4; bus.we = 1; bus.waddr = 9; bus.wdata = 32'h12;
        tick();
        idle();
        bus.rs1_re = 1; bus.rs1_addr = 9; bus.rs2_re = 1; bus.rs2_addr = 4;
        #1;
        checks++;
        if ({bus.rs1_data, bus.rs1_busy, bus.rs2_busy, bus.busy_cnt} !== {32'h12, 1'b0, 1'b0, 6'd0}) begin
            failures++;
            $display("FAIL flush got x9=%h b1=%b b4=%b cnt=%0d exp 12 0 0 0", bus.rs1_data, bus.rs1_busy, bus.rs2_busy, bus.busy_cnt);
        end
        for (int r = 1; r <= 7; r++) begin
            bus.rs1_addr = AW'(r);
            #1;
            checks++;
            if (bus.rs1_busy !== 1'b0) begin
                failures++;
                $display("FAIL flush_busy x%0d got=%b exp=0", r, bus.rs1_busy);
            end
        end
        idle();
    endtask

    task automatic test_x0();
        bus.we = 1; bus.waddr = 0; bus.wdata = 32'hFFFF_FFFF; bus.rsv_valid = 1; bus.rsv_addr = 0;
        tick();
        idle();
        bus.rs1_re = 1; bus.rs1_addr = 0;
        #1;
        checks++;
        if ({bus.rs1_data, bus.rs1_busy, bus.busy_cnt} !== {32'h0, 1'b0, 6'd0}) begin
            failures++;
            $display("FAIL x0 got data=%h busy=%b cnt=%0d exp 0 0 0", bus.rs1_data, bus.rs1_busy, bus.busy_cnt);
        end
        idle();
    endtask

    task automatic test_bypass();
        logic [DW-1:0] old;
        bus.we = 1; bus.waddr = 6; bus.wdata = 32'h0BAD_F00D;
        tick();
        idle();
        old = 32'h0BAD_F00D;
        bus.rsv_valid = 1; bus.rsv_addr = 6;
        tick();
        idle();
        bus.we = 1; bus.waddr = 6; bus.wdata = 32'h55; bus.rs2_re = 1; bus.rs2_addr = 6;
        #1;
        checks++;
`ifdef REGFILE_BYPASS_EN
        if ({bus.rs2_data, bus.rs2_busy, bus.stall_o} !== {32'h55, 1'b0, 1'b0}) begin
            failures++;
            $display("FAIL bypass got data=%h busy=%b stall=%b exp 55 0 0", bus.rs2_data, bus.rs2_busy, bus.stall_o);
        end
`else
        if ({bus.rs2_data, bus.rs2_busy, bus.stall_o} !== {old, 1'b1, 1'b1}) begin
            failures++;
            $display("FAIL no_bypass got data=%h busy=%b stall=%b exp %h 1 1", bus.rs2_data, bus.rs2_busy, bus.stall_o, old);
        end
`endif
        tick();
        bus.we = 0;
        #1;
        checks++;
        if ({bus.rs2_data, bus.rs2_busy, bus.busy_cnt} !== {32'h55, 1'b0, 6'd0}) begin
            failures++;
            $display("FAIL after_write_x6 got data=%h busy=%b cnt=%0d exp 55 0 0", bus.rs2_data, bus.rs2_busy, bus.busy_cnt);
        end
        idle();
    endtask

    task automatic test_random();
        for (int n = 0; n < 600; n++) begin
            bus.we        = ($urandom_range(0, 2) != 0);
            bus.waddr     = ($urandom_range(0, 3) == 0) ? AW'($urandom) : AW'($urandom_range(0, 7));
            bus.wdata     = $urandom;
            bus.rsv_valid = ($urandom_range(0, 2) != 0);
            bus.rsv_addr  = ($urandom_range(0, 3) == 0) ? AW'($urandom) : AW'($urandom_range(0, 7));
            bus.flush     = ($urandom_range(0, 40) == 0);
            bus.rs1_re    = ($urandom_range(0, 4) != 0);
            bus.rs2_re    = ($urandom_range(0, 4) != 0);
            bus.rs1_addr  = AW'($urandom_range(0, 9));
            bus.rs2_addr  = AW'($urandom);
            #1;
            checks++;
            if (dut_vec() !== exp_vec()) begin
                failures++;
                $display("FAIL random cycle=%0d got=%h exp=%h", n, dut_vec(), exp_vec());
            end
            tick();
        end
        idle();
    endtask

    task automatic test_async_reset();
        for (int r = 10; r < 14; r++) begin
            bus.rsv_valid = 1; bus.rsv_addr = AW'(r); bus.we = 1; bus.waddr = AW'(r + 8); bus.wdata = $urandom;
            tick();
        end
        idle();
        bus.rs1_re = 1; bus.rs1_addr = 10; bus.rs2_re = 1; bus.rs2_addr = 18;
        #2;
        rst = 1'b0;
        model_reset();
        #1;
        checks++;
        if (dut_vec() !== 73'd0) begin
            failures++;
            $display("FAIL async_reset got=%h exp=0", dut_vec());
        end
        bus.we = 1; bus.waddr = 18; bus.wdata = 32'h1234_5678; bus.rsv_valid = 1; bus.rsv_addr = 10;
        tick();
        bus.we = 0; bus.rsv_valid = 0;
        #1;
        checks++;
        if (dut_vec() !== 73'd0) begin
            failures++;
            $display("FAIL reset_ignores_ops got=%h exp=0", dut_vec());
        end
        rst = 1'b1;
        #1;
        checks++;
        if (dut_vec() !== exp_vec()) begin
            failures++;
            $display("FAIL post_reset got=%h exp=%h", dut_vec(), exp_vec());
        end
        idle();
    endtask

    initial begin
        idle();
        test_reset();
        test_reserve_write();
        test_same_cycle();
        test_flush();
        test_x0();
        test_bypass();
        test_random();
        test_async_reset();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
